// File: rtl/mic_pkg.sv
// Shared sample types for the microphone capture path.
// Also consumed by mic_load so both ends agree on sample width.
package mic_pkg;

    localparam int N = 16;

    typedef logic [N-1:0] sample_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mic_fifo_mem.sv
// Simple dual-port sample store: registered write, combinational read.
// Contents are not reset; the FIFO pointers decide what is valid.
import mic_pkg::*;

module mic_fifo_mem #(
    parameter int W     = mic_pkg::N,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mic_sample_fifo.sv
// First-word-fall-through sample FIFO with frame marking and sticky overflow.
// Define MIC_FIFO_DROP_COUNT_EN to add a saturating 16-bit drop counter.
import mic_pkg::*;

module mic_sample_fifo #(
    parameter int N         = mic_pkg::N,
    parameter int DEPTH     = 64,
    parameter int FRAME_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid,
    input  logic [N-1:0]             sample_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clear_overflow
`ifdef MIC_FIFO_DROP_COUNT_EN
    ,output logic [15:0]             drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_LEN - 1);

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          ovf_q, ovf_d;

    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [N-1:0]  rdata;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && out_ready;
    // A pop frees the slot the write lands in, so full+pop still accepts.
    assign push  = valid && (!full || pop);
    assign drop  = valid && full && !pop;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        frm_d = frm_q;
        ovf_d = (ovf_q && !clear_overflow) || drop;
        if (push) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d  = rd_q + PW'(1);
            frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            frm_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            frm_q <= frm_d;
            ovf_q <= ovf_d;
        end
    end

    mic_fifo_mem #(
        .W     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_q[AW-1:0]),
        .wdata_i (sample_data),
        .raddr_i (rd_q[AW-1:0]),
        .rdata_o (rdata)
    );

    assign out_valid = !empty;
    assign out_data  = out_valid ? rdata : '0;
    assign out_last  = out_valid && (frm_q == FRM_LAST);
    assign level     = wr_q - rd_q;
    assign overflow  = ovf_q;

`ifdef MIC_FIFO_DROP_COUNT_EN
    logic [15:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d = dcnt_q;
        if (clear_overflow) begin
            dcnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && dcnt_q != 16'hFFFF) begin
            dcnt_d = dcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    assign drop_count = dcnt_q;
`endif

endmodule

// File: tb/tb_mic_sample_fifo.sv
// Directed bench for mic_sample_fifo: vector table plus corner sequences.
// Drop counter checks apply when MIC_FIFO_DROP_COUNT_EN is defined.
module tb_mic_sample_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [15:0] sample_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [6:0]  level;
    logic        overflow;
    logic        clear_overflow;
`ifdef MIC_FIFO_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int errors = 0;
    int checks = 0;

    mic_sample_fifo #(
        .N         (16),
        .DEPTH     (64),
        .FRAME_LEN (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid          (valid),
        .sample_data    (sample_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef MIC_FIFO_DROP_COUNT_EN
        ,.drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [15:0] dat;
        logic        rdy;
        logic        clr;
        logic [6:0]  lvl;
        logic        ov;
        logic [15:0] od;
        logic        ovf;
    } vec_t;

    vec_t vt[10];
    logic [15:0] sine[64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0] = '{1'b1, 16'h8000, 1'b0, 1'b0, 7'd1, 1'b1, 16'h8000, 1'b0};
        vt[1] = '{1'b1, 16'h8c8b, 1'b0, 1'b0, 7'd2, 1'b1, 16'h8000, 1'b0};
        vt[2] = '{1'b1, 16'h98f8, 1'b0, 1'b0, 7'd3, 1'b1, 16'h8000, 1'b0};
        vt[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 7'd2, 1'b1, 16'h8c8b, 1'b0};
        vt[4] = '{1'b1, 16'h1234, 1'b1, 1'b0, 7'd2, 1'b1, 16'h98f8, 1'b0};
        vt[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 7'd1, 1'b1, 16'h1234, 1'b0};
        vt[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 16'h0000, 1'b0};
        vt[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 7'd0, 1'b0, 16'h0000, 1'b0};
        vt[8] = '{1'b1, 16'h5555, 1'b1, 1'b0, 7'd1, 1'b1, 16'h5555, 1'b0};
        vt[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 16'h0000, 1'b0};

        for (int i = 0; i < 64; i++) begin
            sine[i] = 16'($rtoi($floor(32767.0 *
                      $sin(2.0 * 3.141592653589793 * i / 64.0))) + 32768);
        end

        rst_n          = 1'b0;
        valid          = 1'b1;
        sample_data    = 16'hDEAD;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        #2;
        chk("rst_level", level, 7'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_overflow", overflow, 1'b0);
`ifdef MIC_FIFO_DROP_COUNT_EN
        chk("rst_drop_count", drop_count, 16'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        valid = 1'b0;
        chk("valid_in_reset_ignored", level, 7'd0);

        for (int i = 0; i < 10; i++) begin
            valid          = vt[i].vld;
            sample_data    = vt[i].dat;
            out_ready      = vt[i].rdy;
            clear_overflow = vt[i].clr;
            tick();
            chk($sformatf("vec%0d_level", i), level, vt[i].lvl);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].ov);
            chk($sformatf("vec%0d_out_data", i), out_data, vt[i].od);
            chk($sformatf("vec%0d_overflow", i), overflow, vt[i].ovf);
        end
        valid          = 1'b0;
        clear_overflow = 1'b0;

        chk("sine_endpoints", {sine[0], sine[63]}, {16'h8000, 16'h7374});
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            valid       = 1'b1;
            sample_data = sine[i];
            tick();
            valid = 1'b0;
            chk($sformatf("sine%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("sine%0d_data", i), out_data, sine[i]);
            chk($sformatf("sine%0d_last", i), out_last, (i == 63));
            tick();
            chk($sformatf("sine%0d_drained", i), level, 7'd0);
            tick();
            tick();
        end

        pulse_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 65; i++) begin
            valid       = 1'b1;
            sample_data = 16'h0100 + 16'(i);
            tick();
        end
        valid = 1'b0;
        chk("ovf_level", level, 7'd64);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_head", out_data, 16'h0100);
`ifdef MIC_FIFO_DROP_COUNT_EN
        chk("ovf_drop_count", drop_count, 16'd1);
`endif

        valid       = 1'b1;
        sample_data = 16'hAAAA;
        out_ready   = 1'b1;
        tick();
        valid = 1'b0;
        chk("fullpp_level", level, 7'd64);
        chk("fullpp_head", out_data, 16'h0101);
        chk("fullpp_overflow_sticky", overflow, 1'b1);
        for (int k = 0; k < 62; k++) tick();
        chk("drain_frame_end_data", out_data, 16'h013F);
        chk("drain_frame_end_last", out_last, 1'b1);
        tick();
        out_ready = 1'b0;
        chk("drain_tail_data", out_data, 16'hAAAA);
        chk("drain_tail_level", level, 7'd1);
        chk("drain_tail_last", out_last, 1'b0);

        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clear_overflow", overflow, 1'b0);
`ifdef MIC_FIFO_DROP_COUNT_EN
        chk("clear_drop_count", drop_count, 16'd0);
`endif
        for (int i = 0; i < 63; i++) begin
            valid       = 1'b1;
            sample_data = 16'h0200 + 16'(i);
            tick();
        end
        chk("refill_level", level, 7'd64);
        valid          = 1'b1;
        sample_data    = 16'hBEEF;
        clear_overflow = 1'b1;
        tick();
        valid = 1'b0;
        chk("clr_drop_overflow", overflow, 1'b1);
        chk("clr_drop_head", out_data, 16'hAAAA);
`ifdef MIC_FIFO_DROP_COUNT_EN
        chk("clr_drop_count", drop_count, 16'd1);
`endif
        tick();
        clear_overflow = 1'b0;
        chk("clr_after", overflow, 1'b0);

        pulse_reset();
        for (int i = 0; i < 63; i++) begin
            valid       = 1'b1;
            sample_data = 16'(i);
            out_ready   = 1'b0;
            tick();
            valid     = 1'b0;
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid       = 1'b1;
            sample_data = 16'h0300 + 16'(i);
            tick();
        end
        valid = 1'b0;
        chk("pre_rst_level", level, 7'd10);
        chk("pre_rst_last", out_last, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", level, 7'd0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_last", out_last, 1'b0);
        tick();
        rst_n       = 1'b1;
        valid       = 1'b1;
        sample_data = 16'h4242;
        tick();
        valid = 1'b0;
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_data", out_data, 16'h4242);
        chk("post_rst_last", out_last, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("post_rst_popped", level, 7'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
